// File: rtl/hazard_scoreboard.sv
// Register scoreboard for long-latency writebacks: RAW/WAW/capacity stall, flush pulse, stall watchdog.
// Optional HAZARD_PERF_EN builds a free-running stall-cycle counter on perf_stall_cycles.
module hazard_scoreboard #(
    parameter int unsigned NREG          = 32,
    parameter int unsigned MAX_OUT       = 4,
    parameter int unsigned STALL_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic        id_rs1_used,
    input  logic        id_rs2_used,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  id_rd,
    input  logic        id_rd_wr,
    input  logic        id_long_lat,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic        ex_mispredict,
    output logic        hazard_stall,
    output logic        hazard_flush,
    output logic [3:0]  outstanding,
    output logic        stall_timeout,
    output logic [31:0] perf_stall_cycles
);

    logic [NREG-1:1] busy;
    logic [31:0]     busy_v;
    logic [31:0]     busy_nxt;
    logic [3:0]      out_nxt;
    logic [15:0]     wd_cnt;
    logic [15:0]     wd_nxt;
    logic            src_hit;
    logic            full_hit;
    logic            waw_hit;
    logic            issue;

    // A register still counts as pending unless this cycle's writeback retires it (regfile writes through).
    function automatic logic pending(input logic [4:0] r);
        return (r != 5'd0) && busy_v[r] && !(wb_valid && (wb_rd == r));
    endfunction

    always_comb begin
        busy_v           = '0;
        busy_v[NREG-1:1] = busy;
    end

    always_comb begin
        src_hit      = id_valid && ((id_rs1_used && pending(id_rs1)) ||
                                    (id_rs2_used && pending(id_rs2)));
        full_hit     = id_valid && id_long_lat && id_rd_wr && (outstanding == 4'(MAX_OUT));
        waw_hit      = id_valid && id_rd_wr && pending(id_rd);
        hazard_stall = src_hit || full_hit || waw_hit;
        issue        = id_valid && !hazard_stall && !ex_mispredict;
    end

    // Clear before set so a same-cycle writeback and re-issue to one register leaves it busy.
    always_comb begin
        busy_nxt = busy_v;
        if (wb_valid)
            busy_nxt[wb_rd] = 1'b0;
        if (issue && id_long_lat && id_rd_wr && (id_rd != 5'd0))
            busy_nxt[id_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
        out_nxt = '0;
        for (int unsigned i = 0; i < 32; i++)
            out_nxt = out_nxt + 4'(busy_nxt[i]);
    end

    always_comb begin
        wd_nxt = '0;
        if (hazard_stall)
            wd_nxt = (wd_cnt == 16'(STALL_TIMEOUT)) ? wd_cnt : wd_cnt + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy          <= '0;
            outstanding   <= '0;
            hazard_flush  <= 1'b0;
            wd_cnt        <= '0;
            stall_timeout <= 1'b0;
        end else begin
            busy          <= busy_nxt[NREG-1:1];
            outstanding   <= out_nxt;
            hazard_flush  <= ex_mispredict;
            wd_cnt        <= wd_nxt;
            stall_timeout <= stall_timeout || (wd_nxt == 16'(STALL_TIMEOUT));
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            perf_cnt <= '0;
        else if (hazard_stall)
            perf_cnt <= perf_cnt + 32'd1;
    end

    assign perf_stall_cycles = perf_cnt;
`else
    assign perf_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomized and directed bench for hazard_scoreboard against a set-of-pending-registers reference model.
module tb_hazard_scoreboard;

    localparam int unsigned TMO = 8;
    localparam int unsigned MO  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_valid = 1'b0, id_rs1_used = 1'b0, id_rs2_used = 1'b0;
    logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic        id_rd_wr = 1'b0, id_long_lat = 1'b0;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic        ex_mispredict = 1'b0;
    logic        hazard_stall, hazard_flush, stall_timeout;
    logic [3:0]  outstanding;
    logic [31:0] perf_stall_cycles;

    hazard_scoreboard #(.NREG(32), .MAX_OUT(MO), .STALL_TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_rd_wr(id_rd_wr),
        .id_long_lat(id_long_lat), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .ex_mispredict(ex_mispredict), .hazard_stall(hazard_stall),
        .hazard_flush(hazard_flush), .outstanding(outstanding),
        .stall_timeout(stall_timeout), .perf_stall_cycles(perf_stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit v, u1, u2, rdwr, ll, wbv, misp;
        bit [4:0] rs1, rs2, rd, wbrd;
    } in_t;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Reference model: set of registers awaiting writeback, plus plain counters.
    bit          pend [32];
    bit          m_flush;
    int unsigned m_wd;
    bit          m_to;
    bit [31:0]   m_perf;
    in_t         cur;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int unsigned n_pend();
        int unsigned n = 0;
        foreach (pend[i]) if (pend[i]) n++;
        return n;
    endfunction

    function automatic bit waits_on(input bit [4:0] r);
        if (r == 0 || !pend[r]) return 0;
        return !(cur.wbv && cur.wbrd == r);
    endfunction

    function automatic bit m_stall();
        if (!cur.v) return 0;
        if (cur.u1 && waits_on(cur.rs1)) return 1;
        if (cur.u2 && waits_on(cur.rs2)) return 1;
        if (cur.ll && cur.rdwr && n_pend() == MO) return 1;
        if (cur.rdwr && waits_on(cur.rd)) return 1;
        return 0;
    endfunction

    function automatic in_t idle();
        in_t t;
        t = '{default: 0};
        return t;
    endfunction

    function automatic in_t load(input bit [4:0] rd);
        in_t t = idle();
        t.v = 1; t.ll = 1; t.rdwr = 1; t.rd = rd;
        return t;
    endfunction

    function automatic in_t use_rs1(input bit [4:0] rs);
        in_t t = idle();
        t.v = 1; t.u1 = 1; t.rs1 = rs;
        return t;
    endfunction

    task automatic model_reset();
        foreach (pend[i]) pend[i] = 0;
        m_flush = 0; m_wd = 0; m_to = 0; m_perf = '0;
    endtask

    task automatic drive(input in_t t);
        @(negedge clk);
        cur = t;
        id_valid = t.v; id_rs1_used = t.u1; id_rs2_used = t.u2;
        id_rs1 = t.rs1; id_rs2 = t.rs2; id_rd = t.rd; id_rd_wr = t.rdwr;
        id_long_lat = t.ll; wb_valid = t.wbv; wb_rd = t.wbrd; ex_mispredict = t.misp;
        #1;
    endtask

    task automatic check_outputs();
        check_val("stall", {31'd0, hazard_stall}, {31'd0, m_stall()});
        check_val("outstanding", {28'd0, outstanding}, n_pend());
        check_val("flush", {31'd0, hazard_flush}, {31'd0, m_flush});
        check_val("timeout", {31'd0, stall_timeout}, {31'd0, m_to});
        check_val("perf", perf_stall_cycles, m_perf);
    endtask

    task automatic step();
        bit st;
        st = m_stall();
        @(posedge clk);
        if (cur.wbv) pend[cur.wbrd] = 0;
        if (cur.v && !st && !cur.misp && cur.ll && cur.rdwr && cur.rd != 0) pend[cur.rd] = 1;
        m_flush = cur.misp;
        m_wd = st ? ((m_wd + 1 > TMO) ? TMO : m_wd + 1) : 0;
        if (m_wd == TMO) m_to = 1;
`ifdef HAZARD_PERF_EN
        if (st) m_perf = m_perf + 32'd1;
`endif
    endtask

    task automatic cyc(input in_t t);
        drive(t);
        check_outputs();
        step();
    endtask

    // Reset asserted between edges; outputs must clear without a clock edge.
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("rst_stall", {31'd0, hazard_stall}, 32'd0);
        check_val("rst_outstanding", {28'd0, outstanding}, 32'd0);
        check_val("rst_flush", {31'd0, hazard_flush}, 32'd0);
        check_val("rst_timeout", {31'd0, stall_timeout}, 32'd0);
        check_val("rst_perf", perf_stall_cycles, 32'd0);
        model_reset();
        drive(idle());
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_outputs();
        step();
    endtask

    task automatic random_run(input int unsigned n);
        in_t t;
        for (int unsigned k = 0; k < n; k++) begin
            t.v    = ($urandom_range(0, 9) < 8);
            t.u1   = $urandom_range(0, 1);
            t.u2   = ($urandom_range(0, 3) == 0);
            t.rs1  = 5'($urandom_range(0, 7));
            t.rs2  = 5'($urandom_range(0, 7));
            t.rd   = 5'($urandom_range(0, 7));
            t.rdwr = ($urandom_range(0, 3) != 0);
            t.ll   = $urandom_range(0, 1);
            t.wbv  = ($urandom_range(0, 9) < 4);
            t.wbrd = 5'($urandom_range(0, 7));
            t.misp = ($urandom_range(0, 9) == 0);
            cyc(t);
        end
    endtask

    initial begin
        in_t t;
        model_reset();
        cur = idle();
        repeat (2) @(posedge clk);
        do_reset();

        // Load-use: stall, then same-cycle writeback releases it.
        cyc(load(5));
        drive(use_rs1(5));
        check_val("lu_stall", {31'd0, hazard_stall}, 32'd1);
        check_outputs(); step();
        t = use_rs1(5); t.wbv = 1; t.wbrd = 5;
        drive(t);
        check_val("lu_wb_stall", {31'd0, hazard_stall}, 32'd0);
        check_val("lu_out_before", {28'd0, outstanding}, 32'd1);
        check_outputs(); step();
        drive(idle());
        check_val("lu_out_after", {28'd0, outstanding}, 32'd0);
        check_outputs(); step();

        // Capacity limit.
        do_reset();
        for (int unsigned r = 1; r <= 4; r++) cyc(load(5'(r)));
        drive(load(6));
        check_val("lim_stall", {31'd0, hazard_stall}, 32'd1);
        check_val("lim_out", {28'd0, outstanding}, 32'd4);
        check_outputs(); step();
        t = load(6); t.wbv = 1; t.wbrd = 2;
        cyc(t);
        cyc(load(6));
        drive(idle());
        check_val("lim_out_refill", {28'd0, outstanding}, 32'd4);
        check_outputs(); step();

        // Same-cycle writeback and re-issue of one register.
        do_reset();
        cyc(load(7));
        t = load(7); t.wbv = 1; t.wbrd = 7;
        cyc(t);
        drive(use_rs1(7));
        check_val("sim_busy7", {31'd0, hazard_stall}, 32'd1);
        check_val("sim_out", {28'd0, outstanding}, 32'd1);
        check_outputs(); step();

        // Mispredict blocks issue and yields one flush pulse; then back-to-back.
        do_reset();
        t = load(9); t.misp = 1;
        cyc(t);
        drive(use_rs1(9));
        check_val("mp_flush", {31'd0, hazard_flush}, 32'd1);
        check_val("mp_busy9", {31'd0, hazard_stall}, 32'd0);
        check_outputs(); step();
        drive(idle());
        check_val("mp_flush_end", {31'd0, hazard_flush}, 32'd0);
        check_outputs(); step();
        t = idle(); t.misp = 1;
        cyc(t); cyc(t); cyc(idle()); cyc(idle());

        // Watchdog: sustained stall, sticky flag, then async reset.
        do_reset();
        cyc(load(5));
        for (int unsigned k = 0; k < TMO; k++) cyc(use_rs1(5));
        drive(idle());
        check_val("wd_fired", {31'd0, stall_timeout}, 32'd1);
        check_outputs(); step();
        cyc(idle());
`ifdef HAZARD_PERF_EN
        check_val("perf_count", perf_stall_cycles, 32'd8);
`else
        check_val("perf_tied", perf_stall_cycles, 32'd0);
`endif
        do_reset();

        random_run(1500);
        do_reset();
        random_run(1500);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter NREG, default 32: architectural register count; x0 is never busy.
REQ-002 Parameter MAX_OUT, default 4, range 1..15: maximum outstanding long-latency writes.
REQ-003 Parameter STALL_TIMEOUT, default 255, range 1..65535: consecutive stall cycles before the watchdog fires.
REQ-004 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port rst_n, input, 1: asynchronous active-low reset.
REQ-006 Ports id_valid, id_rs1_used and id_rs2_used, inputs, 1 each: ID holds an instruction, and it reads rs1/rs2.
REQ-007 Ports id_rs1 and id_rs2, inputs, 5 each: ID source register indices.
REQ-008 Ports id_rd, input, 5, and id_rd_wr, input, 1: ID destination index and write enable.
REQ-009 Port id_long_lat, input, 1: ID instruction is a load, mul or div with an unknown writeback latency.
REQ-010 Ports wb_valid, input, 1, and wb_rd, input, 5: a long-latency result is written back this cycle.
REQ-011 Port ex_mispredict, input, 1: EX has resolved a mispredicted branch or jump.
REQ-012 Port hazard_stall, output, 1: combinational; holds IF/ID this cycle; drives pipeline control.
REQ-013 Port hazard_flush, output, 1: registered one-cycle flush request to pipeline control.
REQ-014 Port outstanding, output, 4: count of busy registers.
REQ-015 Port stall_timeout, output, 1: sticky watchdog flag.
REQ-016 Port perf_stall_cycles, output, 32: stall-cycle counter.

Function
REQ-017 Keep busy[NREG-1:1] bits; busy[0] always reads 0.
REQ-018 src_hit = id_valid and ((id_rs1_used, id_rs1 != 0, busy[id_rs1], and not (wb_valid with wb_rd == id_rs1)) or the same term for rs2); a same-cycle WB match does not stall because the regfile writes through.
REQ-019 hazard_stall = src_hit, or id_valid and id_long_lat and id_rd_wr with outstanding == MAX_OUT, or a WAW case: busy[id_rd] with id_rd_wr and id_rd != 0 and no same-cycle WB clear.
REQ-020 Issue occurs when id_valid, not hazard_stall and not ex_mispredict; a long_lat issue with id_rd_wr and id_rd != 0 sets busy[id_rd] at the next edge.
REQ-021 wb_valid clears busy[wb_rd] at the next edge; if an issue sets the same register in the same cycle, the set wins.
REQ-022 wb_valid on a register that is not busy is ignored; outstanding is unchanged.
REQ-023 outstanding = popcount(busy); it is updated on the same edge as busy and never exceeds MAX_OUT.
REQ-024 hazard_flush is 1 on the cycle after ex_mispredict is 1, otherwise 0; back-to-back mispredicts give back-to-back pulses.
REQ-025 ex_mispredict blocks issue in that cycle; busy bits of older in-flight instructions are retained.
REQ-026 The watchdog counter increments each cycle hazard_stall is 1 and clears when it is 0; when the count reaches STALL_TIMEOUT, stall_timeout sets and stays at 1 until reset.
REQ-027 The watchdog counter saturates at STALL_TIMEOUT and does not wrap.

Reset
REQ-028 While rst_n is 0, independent of clk:
- busy, outstanding, hazard_flush, stall_timeout, the watchdog counter and perf_stall_cycles are 0.
- hazard_stall is 0 because busy is clear.
REQ-029 Reset asserted mid-operation discards all busy state immediately; the first edge after release evaluates against an empty scoreboard.

Configuration
REQ-030 Macro HAZARD_PERF_EN: when defined, perf_stall_cycles increments by 1 each cycle hazard_stall is 1, wrapping from 0xFFFFFFFF to 0.
REQ-031 When HAZARD_PERF_EN is undefined, perf_stall_cycles is tied to 0, no counter register is built, and all other behaviour is identical.

Verification
REQ-032 Load-use: issue long_lat to rd=5, next cycle ID rs1=5 used -> hazard_stall=1; wb_valid wb_rd=5 that cycle -> stall=0, outstanding goes 1->0.
REQ-033 Limit: issue 4 loads to rd=1..4 with no WB, 5th load to rd=6 -> hazard_stall=1, outstanding=4; WB rd=2 -> issue proceeds, outstanding stays 4.
REQ-034 Simultaneous: busy[7]=1, same cycle wb_rd=7 and issue load rd=7 -> busy[7]=1 after the edge, outstanding unchanged.
REQ-035 Mispredict: ex_mispredict=1 for 1 cycle with an issuable load rd=9 in ID -> busy[9] stays 0, hazard_flush=1 exactly one cycle later.
REQ-036 Watchdog (STALL_TIMEOUT=8): hold a stall for 8 cycles -> stall_timeout=1 and stays after the stall clears; rst_n low mid-run -> all outputs 0 immediately.
REQ-037 HAZARD_PERF_EN defined: 3 stall cycles -> perf_stall_cycles=3; undefined -> perf_stall_cycles=0.
